// File: rtl/puf_pkg.sv
// Shared constants, FSM state encoding and CRP record for the arbiter-PUF CRP collector.
package puf_pkg;
  localparam int CW = 16;
  localparam logic [CW-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [CW-1:0] SEED_ALT  = 16'hACE1;

  typedef enum logic [2:0] {IDLE, LOAD, FIRE, REARM, EMIT, FIN} puf_state_t;

  typedef struct packed {
    logic [CW-1:0] chal;
    logic [CW-1:0] resp;
  } crp_t;

  // x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0
  function automatic logic [CW-1:0] lfsr_step(input logic [CW-1:0] s);
    return {s[CW-2:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/puf_lfsr16.sv
// Challenge generator: loadable 16-bit Fibonacci LFSR with a zero-seed substitute.
module puf_lfsr16
  import puf_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          adv,
  output logic [CW-1:0] q,
  output logic [CW-1:0] nxt
);
  assign nxt = lfsr_step(q);

  always_ff @(posedge clk) begin
    if (!rst_n)    q <= '0;
    else if (load) q <= (load_val == '0) ? SEED_ALT : load_val;
    else if (adv)  q <= nxt;
  end
endmodule

// File: rtl/puf_crp_collector.sv
// Drives the XOR arbiter PUF: fires REPEAT evaluations per challenge, majority-votes each
// response bit and presents the resulting CRP on a valid/ready port.
module puf_crp_collector
  import puf_pkg::*;
#(
  parameter int REPEAT     = 5,
  parameter int PULSE_CYC  = 4,
  parameter int SETTLE_CYC = 3,
  parameter int REARM_CYC  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] seed,
  input  logic [15:0]   num_crp,
  output logic          busy,
  output logic          done,
  output logic          puf_pulse,
  output logic [CW-1:0] puf_challenge,
  input  logic [CW-1:0] puf_response,
  output logic          crp_valid,
  input  logic          crp_ready,
  output logic [CW-1:0] crp_challenge,
  output logic [CW-1:0] crp_response
);
  localparam int VW = $clog2(REPEAT + 1);
  localparam int PW = $clog2(PULSE_CYC + REARM_CYC);
  localparam logic [PW-1:0] PH_FIRE_END  = PW'(PULSE_CYC - 1);
  localparam logic [PW-1:0] PH_REARM_END = PW'(PULSE_CYC + REARM_CYC - 1);
  // two extra cycles cover the synchronizer latency
  localparam logic [PW-1:0] PH_SAMPLE    = PW'(SETTLE_CYC + 2);
  localparam logic [VW-1:0] EVAL_LAST    = VW'(REPEAT - 1);
  localparam logic [VW-1:0] HALF         = VW'(REPEAT / 2);

  puf_state_t state;
  logic [1:0][CW-1:0]   rsync;
  logic [CW-1:0][VW-1:0] votes;
  logic [CW-1:0]        maj;
  logic [VW-1:0]        eval_cnt;
  logic [PW-1:0]        ph;
  logic [15:0]          remaining;
  logic                 first;
  crp_t                 crp_q;
  logic [CW-1:0]        lfsr_q, lfsr_nxt;
  logic                 accept;

  assign accept        = (state == IDLE) && start && !done;
  assign crp_challenge = crp_q.chal;
  assign crp_response  = crp_q.resp;

  puf_lfsr16 u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (seed),
    .adv      ((state == LOAD) && !first),
    .q        (lfsr_q),
    .nxt      (lfsr_nxt)
  );

  for (genvar i = 0; i < CW; i++) begin : g_maj
    assign maj[i] = votes[i] > HALF;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rsync <= '0;
    else        rsync <= {rsync[0], puf_response};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      puf_pulse     <= 1'b0;
      puf_challenge <= '0;
      crp_valid     <= 1'b0;
      crp_q         <= '0;
      votes         <= '0;
      eval_cnt      <= '0;
      ph            <= '0;
      remaining     <= '0;
      first         <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (accept) begin
          remaining <= num_crp;
          first     <= 1'b1;
          busy      <= 1'b1;
          state     <= (num_crp == 16'd0) ? FIN : LOAD;
        end
        LOAD: begin
          puf_challenge <= first ? lfsr_q : lfsr_nxt;
          first         <= 1'b0;
          votes         <= '0;
          eval_cnt      <= '0;
          ph            <= '0;
          puf_pulse     <= 1'b1;
          state         <= FIRE;
        end
        FIRE, REARM: begin
          ph <= ph + PW'(1);
          if (ph == PH_SAMPLE)
            for (int i = 0; i < CW; i++)
              votes[i] <= votes[i] + {{(VW-1){1'b0}}, rsync[1][i]};
          if (state == FIRE && ph == PH_FIRE_END) begin
            puf_pulse <= 1'b0;
            state     <= REARM;
          end else if (state == REARM && ph == PH_REARM_END) begin
            ph <= '0;
            if (eval_cnt == EVAL_LAST) begin
              crp_valid  <= 1'b1;
              crp_q.chal <= puf_challenge;
              crp_q.resp <= maj;
              state      <= EMIT;
            end else begin
              eval_cnt  <= eval_cnt + VW'(1);
              puf_pulse <= 1'b1;
              state     <= FIRE;
            end
          end
        end
        EMIT: if (crp_ready) begin
          crp_valid <= 1'b0;
          remaining <= remaining - 16'd1;
          state     <= (remaining == 16'd1) ? FIN : LOAD;
        end
        FIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_puf_crp_collector.sv
// Bench for puf_crp_collector: behavioural PUF with injectable flips, LFSR/majority reference model.
module tb_puf_crp_collector;
  localparam int REPEAT = 5, PULSE_CYC = 4, SETTLE_CYC = 3, REARM_CYC = 4;
  localparam int LAT = 2 + REPEAT * (PULSE_CYC + REARM_CYC);

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, crp_ready = 1'b0;
  logic [15:0] seed = '0, num_crp = '0, puf_response = '0;
  logic        busy, done, puf_pulse, crp_valid;
  logic [15:0] puf_challenge, crp_challenge, crp_response;

  puf_crp_collector #(.REPEAT(REPEAT), .PULSE_CYC(PULSE_CYC), .SETTLE_CYC(SETTLE_CYC),
                      .REARM_CYC(REARM_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .num_crp(num_crp),
    .busy(busy), .done(done), .puf_pulse(puf_pulse), .puf_challenge(puf_challenge),
    .puf_response(puf_response), .crp_valid(crp_valid), .crp_ready(crp_ready),
    .crp_challenge(crp_challenge), .crp_response(crp_response));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ideal PUF: an arbitrary fixed mixing of the challenge
  function automatic logic [15:0] puf_f(input logic [15:0] c);
    return {c[7:0], c[15:8]} ^ (c << 3) ^ 16'h3C5A;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  // PUF model + pulse-width monitor
  logic [4:0]  cur_pat = '0;
  bit          cur_noise = 0, mon_en = 1, prev_pulse = 0;
  int          rises = 0, hi_w = 0, lo_w = 0, done_cnt = 0;
  logic [15:0] flips [REPEAT];

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_pulse = 0; hi_w = 0; lo_w = 0;
    end else begin
      if (puf_pulse && !prev_pulse) begin
        int e;
        logic [15:0] fl;
        e = rises % REPEAT;
        if (mon_en && e != 0) chk("rearm_width", lo_w, REARM_CYC);
        fl = cur_pat[e] ? 16'h0008 : 16'h0000;
        if (cur_noise)
          for (int b = 0; b < 16; b++) if ($urandom_range(7) == 0) fl[b] = ~fl[b];
        flips[e] = fl;
        puf_response = puf_f(puf_challenge) ^ fl;
        rises++;
        hi_w = 1;
      end else if (puf_pulse) hi_w++;
      if (!puf_pulse && prev_pulse) begin
        if (mon_en) chk("pulse_width", hi_w, PULSE_CYC);
        lo_w = 1;
      end else if (!puf_pulse) lo_w++;
      prev_pulse = puf_pulse;
      if (done) done_cnt++;
    end
  end

  task automatic run(input logic [15:0] sd, input int n, input logic [4:0] pat, input int stall,
                     input bit noise, output logic [15:0] first_chal, output logic [15:0] first_resp);
    logic [15:0] mchal, base, exp_resp, hold_c, hold_r;
    int cnt, d0, ones;
    bit stable;
    first_chal = 'x; first_resp = 'x;
    cur_pat = pat; cur_noise = noise; rises = 0; mon_en = 1;
    d0 = done_cnt;
    mchal = (sd == 16'h0) ? 16'hACE1 : sd;
    @(negedge clk); start = 1'b1; seed = sd; num_crp = 16'(n);
    @(negedge clk); start = 1'b0; cnt = 1;
    chk("busy_after_start", busy, 1);
    for (int k = 0; k < n; k++) begin
      if (k > 0) mchal = lfsr_next(mchal);
      while (!crp_valid && cnt < 400) begin @(negedge clk); cnt++; end
      if (!crp_valid) begin chk("valid_timeout", 0, 1); return; end
      if (k == 0) chk("first_latency", cnt, LAT);
      chk("evals_per_crp", rises, (k + 1) * REPEAT);
      base = puf_f(mchal);
      for (int b = 0; b < 16; b++) begin
        ones = 0;
        for (int e = 0; e < REPEAT; e++) begin
          logic [15:0] r;
          r = base ^ flips[e];
          ones += int'(r[b]);
        end
        exp_resp[b] = (ones > REPEAT / 2);
      end
      chk("crp_challenge", crp_challenge, mchal);
      chk("crp_response", crp_response, exp_resp);
      if (k == 0) begin first_chal = crp_challenge; first_resp = crp_response; end
      if (stall > 0) begin
        hold_c = crp_challenge; hold_r = crp_response; stable = 1;
        repeat (stall) begin
          @(negedge clk);
          if (!crp_valid || puf_pulse || crp_challenge !== hold_c || crp_response !== hold_r) stable = 0;
        end
        chk("stall_stable", stable, 1);
      end
      crp_ready = 1'b1;
      @(negedge clk); crp_ready = 1'b0; cnt = 1;
      chk("valid_drop", crp_valid, 0);
    end
    repeat (3) @(negedge clk);
    chk("done_once", done_cnt - d0, 1);
    chk("busy_after_done", busy, 0);
  endtask

  typedef struct {
    logic [15:0] seed;
    int          num;
    logic [4:0]  pat;
    int          stall;
    logic [15:0] exp_first;
    bit          exp_inv3;
  } vec_t;

  initial begin
    vec_t tbl [6];
    logic [15:0] fc, fr, ideal;
    bit seen;
    tbl[0] = '{16'h0001, 3, 5'b00000, 0,  16'h0001, 0};
    tbl[1] = '{16'h0000, 1, 5'b00000, 0,  16'hACE1, 0};
    tbl[2] = '{16'hBEEF, 1, 5'b00011, 0,  16'hBEEF, 0};
    tbl[3] = '{16'hBEEF, 1, 5'b00111, 0,  16'hBEEF, 1};
    tbl[4] = '{16'h4C21, 1, 5'b10101, 0,  16'h4C21, 1};
    tbl[5] = '{16'h1357, 2, 5'b11000, 50, 16'h1357, 0};

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_outs", {done, puf_pulse, crp_valid}, 0);
    chk("rst_data", {puf_challenge, crp_challenge}, 0);
    chk("rst_resp", crp_response, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run(tbl[i].seed, tbl[i].num, tbl[i].pat, tbl[i].stall, 0, fc, fr);
      ideal = puf_f(tbl[i].exp_first);
      chk("tbl_first_chal", fc, tbl[i].exp_first);
      chk("tbl_bit3", fr[3], ideal[3] ^ tbl[i].exp_inv3);
    end

    for (int r = 0; r < 3; r++)
      run(16'($urandom), int'($urandom_range(1, 3)), 5'b0, 0, 1, fc, fr);

    // num_crp=0: done two cycles after start, nothing fired; start during done ignored
    seen = 0;
    @(negedge clk); start = 1'b1; seed = 16'h1111; num_crp = 16'd0;
    @(negedge clk); start = 1'b0;
    chk("zero_done_early", done, 0);
    chk("zero_busy", busy, 1);
    @(negedge clk);
    chk("zero_done", done, 1);
    start = 1'b1; num_crp = 16'd1;
    @(negedge clk); start = 1'b0;
    chk("start_during_done", busy, 0);
    repeat (12) begin
      @(negedge clk);
      if (puf_pulse || crp_valid) seen = 1;
    end
    chk("zero_no_activity", seen, 0);

    // reset mid-FIRE
    @(negedge clk); start = 1'b1; seed = 16'h2468; num_crp = 16'd2;
    @(negedge clk); start = 1'b0;
    for (int t = 0; t < 20 && !puf_pulse; t++) @(negedge clk);
    chk("fire_reached", puf_pulse, 1);
    @(negedge clk); mon_en = 0; rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ctrl", {busy, done, puf_pulse, crp_valid}, 0);
    chk("midrst_data", {puf_challenge, crp_challenge}, 0);
    chk("midrst_resp", crp_response, 0);
    rst_n = 1'b1;
    run(16'h2468, 2, 5'b00001, 0, 0, fc, fr);
    chk("post_rst_chal", fc, 16'h2468);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
